als_i2c_target: RTL
===================

# als_i2c_target

I2C target (responder) that emulates the ambient-light sensor at the far end of the ALS I2C link. It lets the CCT pipeline run on the FPGA and in simulation without a physical sensor. The block answers the existing ALS master: pointer write, then a repeated-START read of the correlated colour temperature (CCT) registers. The CCT value it presents comes from switches, a test host or a bench driver.

## Interface
- DEV_ADDR, 7'h29: 7-bit target address
- DEFAULT_CCT, 16'd6500: CCT register value after reset
- CHIP_ID, 8'hCA: value of ID register
- clk  in  1  system clock; must be ≥20× SCL frequency
- rst  in  1  synchronous, active-high reset
- scl_in  in  1  SCL pin level (asynchronous)
- sda_in  in  1  SDA pin level (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain, pad logic outside block)
- cct_value  in  16  new CCT in kelvin
- cct_load  in  1  one-cycle strobe; loads cct_value into shadow, sets data_ready
- busy  out  1  high from addressed START until STOP/NACK release
- rd_done  out  1  one-cycle pulse when master NACKs final read byte

## Operation
- Register map, 8-bit pointer (low 2 bits used):
  - 0x00 CCT_L
  - 0x01 CCT_H
  - 0x02 STATUS, bit0 = data_ready
  - 0x03 ID
  - Pointer auto-increments after each read byte, wraps 0x03→0x00.
- Anti-tear: reading CCT_L copies the shadow CCT into a snapshot; CCT_H returns the snapshot high byte. Reading CCT_H clears data_ready. A cct_load in the same cycle as the clear wins (data_ready stays 1).
- FSM states:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits, MSB first.
  - ADDR_ACK: on match, ACK and go to RD_BYTE (R/W=1) or WR_PTR (R/W=0). On mismatch, go to IGNORE, no ACK.
  - WR_PTR: shifts in 8 bits.
  - WR_ACK: ACK, load pointer, then go to WR_DATA.
  - WR_DATA: further bytes are ACKed and discarded (registers are read-only).
  - RD_BYTE: drives 8 bits.
  - RD_ACK: samples master ACK. ACK → next byte. NACK → pulse rd_done, go to IGNORE.
  - IGNORE: waits for START/STOP.
- START or repeated START in any state → ADDR, bit counter cleared, sda_oe=0.
- STOP in any state → IDLE, sda_oe=0, busy=0.
- Bit rules: SDA sampled on detected SCL rising edge; sda_oe updated only after detected SCL falling edge. In RD_BYTE, sda_oe = ~bit. Release happens on the falling edge ending the 8th data bit.
- General call (address 0x00) is not acknowledged.

## Timing
- scl_in/sda_in pass 2-flop synchronizers plus one edge-detect register. A pin edge is seen 3 clk later.
- sda_oe changes exactly 1 clk after a detected SCL falling edge. This keeps SDA stable while SCL is high.
- ACK: sda_oe=1 from the falling edge after bit 8 to the falling edge after bit 9.
- START/STOP are detected only with SCL high in the synchronized domain. Simultaneous SCL and SDA edges in one sample are treated as an SCL edge only.
- Reset values:
  - sda_oe=0, busy=0, rd_done=0
  - pointer=0x00, shadow=DEFAULT_CCT, snapshot=DEFAULT_CCT, data_ready=0
  - FSM=IDLE
- Reset mid-transfer releases SDA on the next cycle. The block then ignores the bus until the next START.

## Structure
- Package als_i2c_pkg holds:
  - FSM state enum
  - register addresses REG_CCT_L/REG_CCT_H/REG_STATUS/REG_ID
  - DEFAULT_CCT and CHIP_ID constants
- Sub-module i2c_line_sync:
  - synchronizers
  - scl_rise/scl_fall/start_det/stop_det pulses
  - reused later by other bus-monitor blocks.
- Top contains FSM, shift register, bit counter, register file.

## Test plan
- Reset, no cct_load. Write ptr 0x00, repeated START, read 2 bytes (ACK, NACK) → bytes 0x64, 0x19 (6500). Then rd_done pulses once.
- cct_load 3200 (0x0C80), read STATUS → 0x01. Read CCT_L/CCT_H → 0x80, 0x0C. Read STATUS again → 0x00.
- Anti-tear: read CCT_L with 6500 loaded; cct_load 0xFFFF before CCT_H → CCT_H returns 0x19.
- Address 0x2A with R/W=0 → no ACK (SDA high at 9th clock), busy stays 0. Next transaction to 0x29 is ACKed.
- Pointer 0x03, read 3 bytes → 0xCA, then the wrapped CCT_L and CCT_H (0x64, 0x19 with default shadow).
- Assert rst during bit 5 of a read byte → sda_oe=0 next cycle. A subsequent full transaction succeeds.

Source files
------------

// File: rtl/als_i2c_pkg.sv
// Shared definitions for the ALS sensor-emulating I2C target: FSM states,
// register map and the default register contents.
package als_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_ACK,
    WR_DATA,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [1:0] REG_CCT_L  = 2'd0;
  localparam logic [1:0] REG_CCT_H  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam logic [15:0] DEFAULT_CCT = 16'd6500;
  localparam logic [7:0]  CHIP_ID     = 8'hCA;

endpackage

// File: rtl/als_i2c_target_if.sv
// Open-drain I2C pin bundle: raw pin levels in, SDA pull-down enable out.
interface als_i2c_target_if;

  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl_in, input sda_in, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_oe);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA pins and produces registered SCL edge and
// START/STOP condition pulses, all aligned with the sda_sync level.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Synchronizer and edge-detect stages carry pin levels only; they are not
  // reset so a reset mid-transfer cannot fabricate a bus condition.
  always_ff @(posedge clk) begin
    scl_s1 <= scl_in;
    scl_s2 <= scl_s1;
    scl_d  <= scl_s2;
    sda_s1 <= sda_in;
    sda_s2 <= sda_s1;
    sda_d  <= sda_s2;
  end

  // START/STOP need SCL high in both samples, so a simultaneous SCL and SDA
  // change is reported as an SCL edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_rise  <= scl_s2 & ~scl_d;
      scl_fall  <= ~scl_s2 & scl_d;
      start_det <= scl_s2 & scl_d & sda_d & ~sda_s2;
      stop_det  <= scl_s2 & scl_d & ~sda_d & sda_s2;
    end
  end

  assign sda_sync = sda_d;

endmodule

// File: rtl/als_i2c_target.sv
// I2C target emulating the ambient-light sensor: pointer write then
// repeated-START read of CCT, STATUS and ID registers with anti-tear snapshot.
module als_i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h29,
  parameter logic [15:0] DEFAULT_CCT = als_i2c_pkg::DEFAULT_CCT,
  parameter logic [7:0]  CHIP_ID     = als_i2c_pkg::CHIP_ID
) (
  input  logic              clk,
  input  logic              rst,
  als_i2c_target_if.slave   bus,
  input  logic [15:0]       cct_value,
  input  logic              cct_load,
  output logic              busy,
  output logic              rd_done
);

  import als_i2c_pkg::*;

  logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

  i2c_line_sync u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_sync (sda_sync)
  );

  i2c_state_e  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_sr;
  logic [6:0]  tx_sr;
  logic [1:0]  ptr;
  logic        sda_oe_q;
  logic [15:0] shadow;
  logic [15:0] snapshot;
  logic        data_ready;
  logic [7:0]  rd_byte;
  logic        rd_load;
  logic        addr_match;

  assign bus.sda_oe = sda_oe_q;

  // General call (address 0) is never acknowledged, whatever DEV_ADDR is.
  assign addr_match = (shift_sr[7:1] == DEV_ADDR) && (shift_sr[7:1] != 7'd0);

  // A read byte is fetched on the SCL fall that ends the preceding ACK bit.
  assign rd_load = scl_fall && !start_det && !stop_det &&
                   ((state == ADDR_ACK && shift_sr[0]) ||
                    (state == RD_ACK && bit_cnt == 4'd9));

  always_comb begin
    rd_byte = CHIP_ID;
    case (ptr)
      REG_CCT_L:  rd_byte = shadow[7:0];
      REG_CCT_H:  rd_byte = snapshot[15:8];
      REG_STATUS: rd_byte = {7'd0, data_ready};
      default:    rd_byte = CHIP_ID;
    endcase
  end

  // Register file: a cct_load in the same cycle as the CCT_H clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= DEFAULT_CCT;
      snapshot   <= DEFAULT_CCT;
      data_ready <= 1'b0;
    end else begin
      if (rd_load && ptr == REG_CCT_L) snapshot <= shadow;
      if (rd_load && ptr == REG_CCT_H) data_ready <= 1'b0;
      if (cct_load) begin
        shadow     <= cct_value;
        data_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      ptr      <= REG_CCT_L;
      sda_oe_q <= 1'b0;
      busy     <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_sr <= {shift_sr[6:0], sda_sync};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (addr_match) begin
                state    <= ADDR_ACK;
                sda_oe_q <= 1'b1;
                busy     <= 1'b1;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (rd_load) begin
              state    <= RD_BYTE;
              tx_sr    <= rd_byte[6:0];
              sda_oe_q <= ~rd_byte[7];
              ptr      <= ptr + 2'd1;
              bit_cnt  <= 4'd0;
            end else if (scl_fall) begin
              state    <= WR_PTR;
              sda_oe_q <= 1'b0;
              bit_cnt  <= 4'd0;
            end
          end
          WR_PTR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_sr <= {shift_sr[6:0], sda_sync};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= WR_ACK;
              sda_oe_q <= 1'b1;
              ptr      <= shift_sr[1:0];
              bit_cnt  <= 4'd0;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state    <= WR_DATA;
              sda_oe_q <= 1'b0;
              bit_cnt  <= 4'd0;
            end
          end
          // Count 9 marks the ACK slot of a discarded data byte.
          WR_DATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_sr <= {shift_sr[6:0], sda_sync};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe_q <= 1'b1;
              bit_cnt  <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= 4'd0;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= RD_ACK;
              sda_oe_q <= 1'b0;
              bit_cnt  <= 4'd0;
            end else if (scl_fall) begin
              sda_oe_q <= ~tx_sr[6];
              tx_sr    <= {tx_sr[5:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_sync) begin
              state   <= IGNORE;
              rd_done <= 1'b1;
              busy    <= 1'b0;
            end else if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (rd_load) begin
              state    <= RD_BYTE;
              tx_sr    <= rd_byte[6:0];
              sda_oe_q <= ~rd_byte[7];
              ptr      <= ptr + 2'd1;
              bit_cnt  <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
